// File: rtl/alu_slice_serial.sv
// alu_slice_serial
//   Multi-cycle ALU. A WIDTH-bit operation is evaluated SLICE bits per clock,
//   least-significant slice first. The carry and the running zero test are
//   carried between slices in registers. Valid/ready handshake on both sides.
//
//   Optional build macro: ALU_LOGIC_BYPASS_EN
//     defined   - non-arithmetic operations are evaluated over the full width
//                 in a single RUN cycle (latency 1); add/sub still take N cycles
//     undefined - every operation takes N = WIDTH/SLICE cycles
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   operands/cntrl valid
//   in_ready   block can accept an operation (IDLE and not in reset)
//   A, B       WIDTH-bit operands
//   cntrl      000 B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 A^B, 001/111 zero
//   out_valid  result and flags valid (DONE)
//   out_ready  consumer accepts result
//   result     WIDTH-bit result
//   negative   result[WIDTH-1]
//   zero       result == 0
//   overflow   signed overflow, add/sub only
//   carry_out  carry out of bit WIDTH-1, add/sub only
module alu_slice_serial #(
   parameter int WIDTH = 64,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       cntrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   generate
      if (SLICE < 1) begin : g_bad_slice
         $error("alu_slice_serial: SLICE must be >= 1");
      end else if (WIDTH % SLICE != 0) begin : g_bad_width
         $error("alu_slice_serial: WIDTH must be a multiple of SLICE");
      end
   endgenerate

   localparam int N  = (SLICE >= 1) ? WIDTH / SLICE : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;
   logic             carry_q, zacc_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] result_q;
   logic             neg_q, zero_q, ovf_q, cout_q;

   // Full-width bitwise operations; also the source of each slice's logic bits.
   function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      case (op)
         3'b000:  return b;
         3'b100:  return a & b;
         3'b101:  return a | b;
         3'b110:  return a ^ b;
         default: return '0;
      endcase
   endfunction

   logic             is_arith, is_sub, wide, last;
   logic [SLICE-1:0] a_s, b_s, slice_res;
   logic [SLICE:0]   sum;
   logic             carry_msb;
   logic [WIDTH-1:0] lw;

   always_comb begin
      is_arith  = (op_q[2:1] == 2'b01);
      is_sub    = (op_q == 3'b011);
      a_s       = a_q[cnt_q*SLICE +: SLICE];
      // Subtraction is A + ~B + 1; the +1 arrives through the preloaded carry.
      b_s       = b_q[cnt_q*SLICE +: SLICE] ^ {SLICE{is_sub}};
      sum       = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
      // Carry into the slice MSB, recovered from the sum bit.
      carry_msb = a_s[SLICE-1] ^ b_s[SLICE-1] ^ sum[SLICE-1];
      lw        = logic_op(op_q, a_q, b_q);
      slice_res = is_arith ? sum[SLICE-1:0] : lw[cnt_q*SLICE +: SLICE];
`ifdef ALU_LOGIC_BYPASS_EN
      wide      = !is_arith;
`else
      wide      = 1'b0;
`endif
      last      = wide || (cnt_q == LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = reset_n;
            if (in_valid && reset_n) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch happens on acceptance; result and flags are built up in RUN.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         result_q <= '0;
         neg_q    <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
         carry_q  <= 1'b0;
         zacc_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (accept) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= cntrl;
            carry_q <= (cntrl[2:1] == 2'b01) & cntrl[0];
            zacc_q  <= 1'b1;
            cnt_q   <= '0;
         end else if (state == RUN) begin
            if (wide) begin
               result_q <= lw;
               neg_q    <= lw[WIDTH-1];
               zero_q   <= (lw == '0);
               ovf_q    <= 1'b0;
               cout_q   <= 1'b0;
            end else begin
               result_q[cnt_q*SLICE +: SLICE] <= slice_res;
               carry_q <= sum[SLICE];
               zacc_q  <= zacc_q & (slice_res == '0);
               cnt_q   <= cnt_q + 1'b1;
               if (last) begin
                  neg_q  <= slice_res[SLICE-1];
                  zero_q <= zacc_q & (slice_res == '0);
                  cout_q <= is_arith & sum[SLICE];
                  ovf_q  <= is_arith & (carry_msb ^ sum[SLICE]);
               end
            end
         end
      end
   end

   assign result    = result_q;
   assign negative  = neg_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign carry_out = cout_q;

endmodule

// File: tb/tb_alu_slice_serial.sv
// tb_alu_slice_serial
//   Scoreboard bench for alu_slice_serial at WIDTH=64, SLICE=8. Expected
//   results come from a full-width reference model and are queued when an
//   operation is accepted, then popped when out_valid rises.
module tb_alu_slice_serial;

   localparam int W = 64;
   localparam int S = 8;
   localparam int N = W / S;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A, B;
   logic [2:0]   cntrl;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         negative, zero, overflow, carry_out;

   always #5 clk = ~clk;

   alu_slice_serial #(.WIDTH(W), .SLICE(S)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .cntrl     (cntrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .negative  (negative),
      .zero      (zero),
      .overflow  (overflow),
      .carry_out (carry_out)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         neg;
      logic         zero;
      logic         ovf;
      logic         cout;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] op);
      exp_t       e;
      logic [W:0] s;
      e.ovf  = 1'b0;
      e.cout = 1'b0;
      e.lat  = N;
      s      = '0;
      case (op)
         3'b000: e.res = b;
         3'b100: e.res = a & b;
         3'b101: e.res = a | b;
         3'b110: e.res = a ^ b;
         3'b010: begin
            s      = {1'b0, a} + {1'b0, b};
            e.res  = s[W-1:0];
            e.cout = s[W];
            e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
         end
         3'b011: begin
            s      = {1'b0, a} + {1'b0, ~b} + 65'd1;
            e.res  = s[W-1:0];
            e.cout = s[W];
            e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
         end
         default: e.res = '0;
      endcase
`ifdef ALU_LOGIC_BYPASS_EN
      if (op[2:1] != 2'b01) e.lat = 1;
`endif
      e.neg  = e.res[W-1];
      e.zero = (e.res == '0);
      return e;
   endfunction

   // Issue one operation, check latency and outputs, optionally stall the
   // consumer for 'hold' cycles while offering a competing operation.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input int hold);
      exp_t         e;
      int           lat;
      int           waitc;
      logic [W-1:0] r0;
      logic [3:0]   f0;
      string        t;
      t = $sformatf("op%0d", op);
      @(negedge clk);
      A         = a;
      B         = b;
      cntrl     = op;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      waitc     = 0;
      while (!in_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!in_ready) begin
         check({t, " accept"}, 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      sb.push_back(model(a, b, op));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A        = ~a;
      B        = ~b;
      lat      = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         lat++;
         #1;
      end
      e = sb.pop_front();
      check({t, " latency"},   64'(lat),       64'(e.lat));
      check({t, " result"},    result,         e.res);
      check({t, " negative"},  64'(negative),  64'(e.neg));
      check({t, " zero"},      64'(zero),      64'(e.zero));
      check({t, " overflow"},  64'(overflow),  64'(e.ovf));
      check({t, " carry_out"}, 64'(carry_out), 64'(e.cout));
      if (hold > 0) begin
         A        = 64'h1234_5678_9ABC_DEF0;
         B        = 64'h0FED_CBA9_8765_4321;
         cntrl    = 3'b010;
         in_valid = 1'b1;
         r0       = result;
         f0       = {negative, zero, overflow, carry_out};
         repeat (hold) begin
            @(posedge clk);
            #1;
            check({t, " hold in_ready"},  64'(in_ready),  64'd0);
            check({t, " hold out_valid"}, 64'(out_valid), 64'd1);
            check({t, " hold result"},    result,         r0);
            check({t, " hold flags"},
                  64'({negative, zero, overflow, carry_out}), 64'(f0));
         end
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check({t, " release in_ready"},  64'(in_ready),  64'd1);
         check({t, " release out_valid"}, 64'(out_valid), 64'd0);
         @(posedge clk);
         #1;
         check({t, " no stray accept"}, 64'(in_ready), 64'd1);
      end else begin
         @(posedge clk);
         #1;
         check({t, " drain out_valid"}, 64'(out_valid), 64'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic [2:0]   rop;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      cntrl     = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset in_ready",  64'(in_ready),  64'd0);
      check("reset result",    result,         64'd0);
      check("reset flags", 64'({negative, zero, overflow, carry_out}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("release in_ready", 64'(in_ready), 64'd1);

      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 0);
      run_op(64'd5, 64'd5, 3'b011, 0);
      run_op(64'd0, 64'd1, 3'b011, 0);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 0);
      run_op(64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 0);
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 5);
      run_op(64'd1, 64'd2, 3'b010, 0);
      run_op(64'hAAAA_5555_0000_FFFF, 64'h1234_5678_9ABC_DEF0, 3'b000, 0);
      run_op(64'hAAAA_5555_0000_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 3'b100, 0);
      run_op(64'hAAAA_5555_0000_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 3'b101, 0);
      run_op(64'hAAAA_5555_0000_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 3'b001, 0);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 0);
      run_op(64'h8000_0000_0000_0000, 64'd1, 3'b011, 0);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 3);

      for (int i = 0; i < 12; i++) begin
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         rop = 3'($urandom_range(0, 7));
         run_op(ra, rb, rop, 0);
      end

      // Reset while slice 3 of an add is being computed.
      @(negedge clk);
      A         = 64'h1111_2222_3333_4444;
      B         = 64'h5555_6666_7777_8888;
      cntrl     = 3'b010;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrun out_valid", 64'(out_valid), 64'd0);
      check("midrun result",    result,         64'd0);
      check("midrun flags", 64'({negative, zero, overflow, carry_out}), 64'd0);
      check("midrun in_ready",  64'(in_ready),  64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("after reset in_ready",  64'(in_ready),  64'd1);
      check("after reset out_valid", 64'(out_valid), 64'd0);
      run_op(64'd2, 64'd3, 3'b010, 0);

      check("scoreboard empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
